sram_lut_ctrl: RTL and testbench

//  Sequencer sitting directly upstream of the 8-block 2048x20 precalculated-value SRAM.
//  - LOAD phase: streams precalculated 20-bit words into consecutive addresses 0..DEPTH-1.
//  - RUN phase: issues single-word lookup reads and returns the data with a valid strobe.

---
 rtl/sram_lut_ctrl_if.sv | 48 ++++
 rtl/sram_lut_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sram_lut_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_lut_ctrl_if.sv
// Bundle between the LUT sequencer, its load/lookup clients and the SRAM.
// Ports: load stream, lookup req/result, status, SRAM A/D/WEN/CEN/Q.
interface sram_lut_ctrl_if #(
  parameter int AW = 11,
  parameter int DW = 20
) ();
  logic          load_start;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          load_done;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_addr;
  logic          q_valid;
  logic [DW-1:0] q_data;
  logic          busy;
  logic [AW-1:0] sram_A;
  logic [DW-1:0] sram_D;
  logic          sram_WEN;
  logic          sram_CEN;
  logic [DW-1:0] sram_Q;
`ifdef SRAM_LUT_CHKSUM_EN
  logic [DW-1:0] load_chksum;
`endif

  modport slave (
    input  load_start, s_valid, s_data,
    input  lu_valid, lu_addr, sram_Q,
    output s_ready, load_done, lu_ready,
    output q_valid, q_data, busy,
    output sram_A, sram_D, sram_WEN, sram_CEN
`ifdef SRAM_LUT_CHKSUM_EN
    , output load_chksum
`endif
  );

  modport master (
    output load_start, s_valid, s_data,
    output lu_valid, lu_addr, sram_Q,
    input  s_ready, load_done, lu_ready,
    input  q_valid, q_data, busy,
    input  sram_A, sram_D, sram_WEN, sram_CEN
`ifdef SRAM_LUT_CHKSUM_EN
    , input load_chksum
`endif
  );
endinterface

// File: rtl/sram_lut_ctrl.sv
// LUT SRAM sequencer: streams a table into SRAM, then serves lookups.
// Ports: clk, rst_n (async low), b (sram_lut_ctrl_if.slave).
// Option SRAM_LUT_CHKSUM_EN adds b.load_chksum (XOR of loaded words).
module sram_lut_ctrl #(
  parameter int AW     = 11,
  parameter int DW     = 20,
  parameter int DEPTH  = 2048,
  parameter int RD_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_lut_ctrl_if.slave b
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LDONE,
    RUN
  } state_t;

  state_t st, st_nx;
  logic   pend, pend_nx;
  logic   ptr_clr;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     a_q;
  logic [DW-1:0]     d_q;
  logic [DW-1:0]     q_q;
  logic              wen_q, cen_q;
  logic              done_q, qv_q;
  logic [RD_LAT-1:0] pipe;

  logic s_rdy, lu_rdy;
  logic wr_en, acc, last, pipe_mt;

  assign s_rdy   = (st == LOAD);
  assign lu_rdy  = (st == RUN) & ~pend;
  assign pipe_mt = (pipe == '0);

  // A word arriving with a restart belongs to the old table: drop it.
  assign wr_en = b.s_valid & s_rdy & ~b.load_start;
  assign acc   = b.lu_valid & lu_rdy;
  assign last  = wr_en & (wr_ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      pend <= 1'b0;
    end else begin
      st   <= st_nx;
      pend <= pend_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    pend_nx = pend;
    ptr_clr = 1'b0;
    unique case (st)
      IDLE: begin
        if (b.load_start) begin
          st_nx   = LOAD;
          ptr_clr = 1'b1;
        end
      end
      LOAD: begin
        if (b.load_start) begin
          ptr_clr = 1'b1;
        end else if (last) begin
          st_nx = LDONE;
        end
      end
      LDONE: begin
        if (b.load_start) begin
          st_nx   = LOAD;
          ptr_clr = 1'b1;
        end else begin
          st_nx = RUN;
        end
      end
      RUN: begin
        // Reload waits until every in-flight read has returned.
        if (pend && pipe_mt) begin
          st_nx   = LOAD;
          pend_nx = 1'b0;
          ptr_clr = 1'b1;
        end else if (b.load_start) begin
          pend_nx = 1'b1;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      a_q    <= '0;
      d_q    <= '0;
      wen_q  <= 1'b1;
      cen_q  <= 1'b1;
      done_q <= 1'b0;
      qv_q   <= 1'b0;
      q_q    <= '0;
      pipe   <= '0;
    end else begin
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
      done_q <= (st == LDONE) & ~b.load_start;
      if (wr_en) begin
        a_q    <= wr_ptr;
        d_q    <= b.s_data;
        wen_q  <= 1'b0;
        cen_q  <= 1'b0;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (acc) begin
        a_q   <= b.lu_addr;
        cen_q <= 1'b0;
      end
      if (ptr_clr) begin
        wr_ptr <= '0;
      end
      pipe <= (pipe << 1) | RD_LAT'(acc);
      qv_q <= pipe[RD_LAT-1];
      if (pipe[RD_LAT-1]) begin
        q_q <= b.sram_Q;
      end
    end
  end

`ifdef SRAM_LUT_CHKSUM_EN
  logic [DW-1:0] chk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (b.load_start) begin
      chk_q <= '0;
    end else if (wr_en) begin
      chk_q <= chk_q ^ b.s_data;
    end
  end

  assign b.load_chksum = chk_q;
`else
  // Checksum disabled: no port, no state.
`endif

  assign b.s_ready   = s_rdy;
  assign b.lu_ready  = lu_rdy;
  assign b.load_done = done_q;
  assign b.q_valid   = qv_q;
  assign b.q_data    = q_q;
  assign b.busy      = (st == LOAD) | (st == LDONE)
                     | ~pipe_mt | pend;
  assign b.sram_A    = a_q;
  assign b.sram_D    = d_q;
  assign b.sram_WEN  = wen_q;
  assign b.sram_CEN  = cen_q;

endmodule

// File: tb/tb_sram_lut_ctrl.sv
// Bench for sram_lut_ctrl: SRAM model, load/lookup drivers, table model.
// Ports: none (top level).
module tb_sram_lut_ctrl;
  localparam int AW     = 11;
  localparam int DW     = 20;
  localparam int DEPTH  = 2048;
  localparam int RD_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sram_lut_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  sram_lut_ctrl #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .b    (bus.slave)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!bus.sram_CEN) begin
      if (!bus.sram_WEN) mem[bus.sram_A] <= bus.sram_D;
      else               bus.sram_Q <= mem[bus.sram_A];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wa [$];
  logic [DW-1:0] wd [$];
  int            wc [$];
  int            ldc [$];
  logic [DW-1:0] qd [$];
  int            qc [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.sram_CEN && !bus.sram_WEN) begin
        wa.push_back(bus.sram_A);
        wd.push_back(bus.sram_D);
        wc.push_back(cyc);
      end
      if (bus.load_done) ldc.push_back(cyc);
      if (bus.q_valid) begin
        qd.push_back(bus.q_data);
        qc.push_back(cyc);
      end
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] ew_a [$];
  logic [DW-1:0] ew_d [$];
  logic [DW-1:0] ea [$];
  int            ec [$];
  logic [AW-1:0] la [$];
  logic [DW-1:0] xr;
  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clrq();
    @(posedge clk);
    wa.delete(); wd.delete(); wc.delete(); ldc.delete();
    qd.delete(); qc.delete(); ea.delete(); ec.delete();
  endtask

  task automatic pulse_ls();
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  function automatic logic [DW-1:0] dgen(input int k, input int i);
    if (k == 0) return DW'(i * 3);
    if (k == 1) return DW'(i * 7 + 1);
    return DW'($urandom);
  endfunction

  // The k-th word accepted after a load_start lands at address k.
  task automatic load_words(input int n, input bit thr, input int dk);
    int i = 0;
    int k = 0;
    int budget = n * 8 + 64;
    logic v;
    logic [DW-1:0] d;
    xr = '0;
    ew_a.delete();
    ew_d.delete();
    while (i < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (!thr)        v = 1'b1;
      else if (k < 40) v = (k % 2 == 0);
      else             v = ($urandom_range(0, 3) != 0);
      d = dgen(dk, i);
      bus.s_valid = v;
      bus.s_data  = d;
      if (v && bus.s_ready) begin
        ref_mem[i] = d;
        ew_a.push_back(AW'(i));
        ew_d.push_back(d);
        xr ^= d;
        i++;
      end
      k++;
    end
    chk("load_budget", i, n);
  endtask

  task automatic run_reads(input bit gaps);
    int idx = 0;
    int budget = la.size() * 8 + 32;
    while (idx < la.size() && budget > 0) begin
      @(negedge clk);
      budget--;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.lu_valid = 1'b0;
      end else begin
        bus.lu_valid = 1'b1;
        bus.lu_addr  = la[idx];
        if (bus.lu_ready) begin
          ea.push_back(ref_mem[la[idx]]);
          ec.push_back(cyc + 1 + RD_LAT);
          idx++;
        end
      end
    end
    @(negedge clk);
    bus.lu_valid = 1'b0;
    chk("read_budget", idx, la.size());
  endtask

  task automatic check_writes(input string tag);
    int bad = 0;
    chk({tag, "_wr_cnt"}, wa.size(), ew_a.size());
    for (int k = 0; k < wa.size() && k < ew_a.size(); k++)
      if (wa[k] !== ew_a[k] || wd[k] !== ew_d[k]) bad++;
    chk({tag, "_wr_seq_bad"}, bad, 0);
  endtask

  task automatic check_reads(input string tag);
    int bad = 0;
    chk({tag, "_rd_cnt"}, qd.size(), ea.size());
    for (int k = 0; k < qd.size() && k < ea.size(); k++)
      if (qd[k] !== ea[k] || qc[k] !== ec[k]) bad++;
    chk({tag, "_rd_bad"}, bad, 0);
  endtask

  task automatic check_load_end(input string tag);
    chk({tag, "_done_cnt"}, ldc.size(), 1);
    if (ldc.size() == 1 && wc.size() > 0)
      chk({tag, "_done_lat"}, ldc[0], wc[wc.size()-1] + 1);
    chk({tag, "_lu_ready"}, bus.lu_ready, 1);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_busy"}, bus.busy, 0);
`ifdef SRAM_LUT_CHKSUM_EN
    chk({tag, "_chksum"}, bus.load_chksum, xr);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cen"}, bus.sram_CEN, 1);
    chk({tag, "_wen"}, bus.sram_WEN, 1);
    chk({tag, "_a"}, bus.sram_A, 0);
    chk({tag, "_d"}, bus.sram_D, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_lu_ready"}, bus.lu_ready, 0);
    chk({tag, "_load_done"}, bus.load_done, 0);
    chk({tag, "_q_valid"}, bus.q_valid, 0);
    chk({tag, "_q_data"}, bus.q_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_start = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.lu_valid   = 1'b0;
    bus.lu_addr    = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    clrq();

    // Reset while word 36 is on the SRAM pins.
    pulse_ls();
    load_words(37, 1'b0, 0);
    @(posedge clk);
    #2;
    chk("t1_cen_pre", bus.sram_CEN, 0);
    chk("t1_a_pre", bus.sram_A, 36);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    check_reset_vals("t1");
    @(negedge clk);
    rst_n = 1'b1;
    clrq();

    // Throttled full load, data = addr*3.
    pulse_ls();
    load_words(DEPTH, 1'b1, 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_writes("t3");
    chk("t3_no_q", qd.size(), 0);
    check_load_end("t3");

    // Back-to-back lookups at table corners.
    clrq();
    la = {11'd0, 11'd1, 11'd2047, 11'd1024};
    run_reads(1'b0);
    repeat (RD_LAT + 2) @(negedge clk);
    #1;
    check_reads("t4");
    for (int k = 0; k < qd.size() && k < la.size(); k++)
      chk("t4_data_addr3", qd[k], DW'(la[k] * 3));
    if (qc.size() == 4)
      chk("t4_consecutive", qc[3] - qc[0], 3);

    // Random lookups with gaps.
    clrq();
    la.delete();
    repeat (40) la.push_back(AW'($urandom_range(0, DEPTH - 1)));
    run_reads(1'b1);
    repeat (RD_LAT + 2) @(negedge clk);
    #1;
    check_reads("rnd1");

    // Reload requested together with the second of two lookups.
    clrq();
    @(negedge clk);
    bus.lu_valid = 1'b1;
    bus.lu_addr  = 11'd5;
    if (bus.lu_ready) begin
      ea.push_back(ref_mem[5]);
      ec.push_back(cyc + 1 + RD_LAT);
    end
    @(negedge clk);
    bus.lu_addr    = 11'd6;
    bus.load_start = 1'b1;
    if (bus.lu_ready) begin
      ea.push_back(ref_mem[6]);
      ec.push_back(cyc + 1 + RD_LAT);
    end
    @(negedge clk);
    bus.lu_valid   = 1'b0;
    bus.load_start = 1'b0;
    #1;
    chk("t5_lu_ready_drop", bus.lu_ready, 0);
    chk("t5_busy", bus.busy, 1);
    chk("t5_expect_two", ea.size(), 2);
    for (int n = 0; n < 20 && !bus.s_ready; n++) @(negedge clk);
    #1;
    chk("t5_enter_load", bus.s_ready, 1);
    check_reads("t5");
    if (qd.size() == 2) begin
      chk("t5_q0", qd[0], 15);
      chk("t5_q1", qd[1], 18);
    end

    // 100 words, then restart.
    load_words(100, 1'b0, 1);
    @(negedge clk);
    bus.s_valid    = 1'b0;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    #1;
    check_writes("t5w");
    if (wa.size() > 0) chk("t5_first_a", wa[0], 0);
    chk("t6_no_done_pre", ldc.size(), 0);
    chk("t6_busy", bus.busy, 1);

    // Full random load after restart, s_valid held high.
    clrq();
    load_words(DEPTH, 1'b0, 2);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_writes("t6");
    check_load_end("t6");

    // Lookups of the new table, including the low words.
    clrq();
    la.delete();
    for (int k = 0; k < 8; k++) la.push_back(AW'(k * 13));
    repeat (32) la.push_back(AW'($urandom_range(0, DEPTH - 1)));
    run_reads(1'b1);
    repeat (RD_LAT + 2) @(negedge clk);
    #1;
    check_reads("rnd2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
